// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Issues word-aligned requests to instruction memory,
// forms IF/ID packets {pc+4, instr}, parks a returned instruction while the
// pipeline is stalled, and handles branch/jump redirects. A redirect while a
// memory request is still in flight drains that request, dropping its data,
// before fetching from the new target.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   stall        hazard hold: nothing may be written to IF/ID
//   redirect     one-cycle pulse, branch/jump taken
//   redirect_pc  redirect target (bits [1:0] ignored)
//   imem_req     instruction-memory request valid
//   imem_addr    fetch address of the outstanding request
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   instruction word, valid with imem_ack
//   ifid_data    IF/ID packet {pc_plus4, instr}, zero unless ifid_wr
//   ifid_wr      IF/ID write enable
//   ifid_flush   IF/ID clear (bubble insert)
//   fetch_count  packets issued since reset (wraps)
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [63:0] ifid_data,
   output logic        ifid_wr,
   output logic        ifid_flush,
   output logic [31:0] fetch_count
);

   // FETCH: request at req_addr outstanding, data issued on ack.
   // HOLD : a returned instruction is parked in hold_buf behind a stall.
   // DRAIN: a redirect arrived while a request was in flight; wait for its
   //        ack and drop the data.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] req_addr;
   logic [31:0] req_addr_nxt;
   logic [63:0] hold_buf;
   logic [63:0] hold_buf_nxt;
   logic        issue;
   logic [63:0] issue_data;
   logic        flush_req;

   logic [31:0] pc_plus4;
   logic [31:0] redirect_tgt;

   // Natural 32-bit addition gives the required wrap from 32'hFFFF_FFFC to 0.
   assign pc_plus4     = pc + 32'd4;
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};

   // The low target bits are architecturally ignored.
   logic unused_redirect_bits;
   assign unused_redirect_bits = ^redirect_pc[1:0];

   // ---------------------------------------------------------------------------
   // Next-state and issue logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_nxt    = state;
      pc_nxt       = pc;
      req_addr_nxt = req_addr;
      hold_buf_nxt = hold_buf;
      issue        = 1'b0;
      issue_data   = 64'd0;
      flush_req    = 1'b0;

      unique case (state)
         FETCH: begin
            if (redirect) begin
               // Redirect wins over ack and stall; any returned data is dropped.
               flush_req = 1'b1;
               pc_nxt    = redirect_tgt;
               if (imem_ack) begin
                  req_addr_nxt = redirect_tgt;
               end else begin
                  // Request still in flight: keep its address until it drains.
                  state_nxt = DRAIN;
               end
            end else if (imem_ack) begin
               if (!stall) begin
                  issue        = 1'b1;
                  issue_data   = {pc_plus4, imem_rdata};
                  pc_nxt       = pc_plus4;
                  req_addr_nxt = pc_plus4;
               end else begin
                  hold_buf_nxt = {pc_plus4, imem_rdata};
                  state_nxt    = HOLD;
               end
            end
         end

         HOLD: begin
            // No request is outstanding here, so imem_ack is not looked at.
            if (redirect) begin
               flush_req    = 1'b1;
               pc_nxt       = redirect_tgt;
               req_addr_nxt = redirect_tgt;
               state_nxt    = FETCH;
            end else if (!stall) begin
               issue        = 1'b1;
               issue_data   = hold_buf;
               pc_nxt       = pc_plus4;
               req_addr_nxt = pc_plus4;
               state_nxt    = FETCH;
            end
         end

         DRAIN: begin
            if (redirect) begin
               // A newer redirect only retargets pc; the old request still drains.
               flush_req = 1'b1;
               pc_nxt    = redirect_tgt;
            end
            if (imem_ack) begin
               // Drop the stale data and restart at the (possibly just updated) pc.
               req_addr_nxt = pc_nxt;
               state_nxt    = FETCH;
            end
         end

         default: begin
            state_nxt    = FETCH;
            req_addr_nxt = pc;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         // NOTE: hold_buf is a plain register, not a memory, and is reset so a
         // packet parked before reset can never reappear afterwards.
         hold_buf    <= 64'd0;
         fetch_count <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values computed by the comb block.
         state       <= state_nxt;
         pc          <= pc_nxt;
         req_addr    <= req_addr_nxt;
         hold_buf    <= hold_buf_nxt;
         if (issue) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Reset forces a bubble and suppresses any write; flush and write are
   // otherwise mutually exclusive because issue only happens without redirect.
   assign imem_req   = (state != HOLD);
   assign imem_addr  = req_addr;
   assign ifid_wr    = issue & ~rst;
   assign ifid_flush = flush_req | rst;
   assign ifid_data  = ifid_wr ? issue_data : 64'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed scenarios for reset, streaming, stall/hold, redirect priority,
// drain, address wrap and asynchronous reset in HOLD, followed by a random
// run compared cycle by cycle against a behavioural fetch model.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [63:0] ifid_data;
   logic        ifid_wr;
   logic        ifid_flush;
   logic [31:0] fetch_count;

   int n_cmp  = 0;
   int n_fail = 0;

   if_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .ifid_data   (ifid_data),
      .ifid_wr     (ifid_wr),
      .ifid_flush  (ifid_flush),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output bundle: {imem_req, imem_addr, ifid_wr, ifid_flush, ifid_data}
   function automatic logic [98:0] obs();
      return {imem_req, imem_addr, ifid_wr, ifid_flush, ifid_data};
   endfunction

   function automatic logic [98:0] pk(input logic req, input logic [31:0] addr,
                                      input logic wr, input logic fl,
                                      input logic [63:0] data);
      return {req, addr, wr, fl, data};
   endfunction

   // Drive one cycle of inputs mid-cycle; outputs are sampled 1 ns later.
   task automatic apply(input logic s, input logic r, input logic [31:0] rpc,
                        input logic a, input logic [31:0] rd);
      @(negedge clk);
      stall       = s;
      redirect    = r;
      redirect_pc = rpc;
      imem_ack    = a;
      imem_rdata  = rd;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [98:0] e;
      @(negedge clk);
      stall = 1'b0; redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #2 rst = 1'b1;
      #1;
      e = pk(1'b1, RST_PC, 1'b0, 1'b1, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
      n_cmp++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h want 0", fetch_count); end
      @(posedge clk); #1;
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL reset_held_edge: got %h want %h", obs(), e); end
      @(negedge clk);
      rst = 1'b0; imem_ack = 1'b0;
   endtask

   task automatic test_stream();
      logic [98:0] e;
      logic [31:0] ins [3];
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ins[i] = $urandom;
         apply(1'b0, 1'b0, 32'd0, 1'b1, ins[i]);
         e = pk(1'b1, RST_PC + 32'(4 * i), 1'b1, 1'b0, {RST_PC + 32'(4 * (i + 1)), ins[i]});
         n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL stream_pkt%0d: got %h want %h", i, obs(), e); end
      end
      apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      n_cmp++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL stream_count: got %0d want 3", fetch_count); end
      n_cmp++; if (imem_addr !== 32'h300C) begin n_fail++; $display("FAIL stream_next_addr: got %h want 300c", imem_addr); end
   endtask

   task automatic test_stall();
      logic [98:0] e;
      logic [31:0] i0;
      i0 = $urandom;
      do_reset();
      apply(1'b1, 1'b0, 32'd0, 1'b1, i0);
      e = pk(1'b1, RST_PC, 1'b0, 1'b0, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL stall_capture: got %h want %h", obs(), e); end
      for (int k = 0; k < 2; k++) begin
         apply(1'b1, 1'b0, 32'd0, 1'b1, $urandom);
         e = pk(1'b0, RST_PC, 1'b0, 1'b0, 64'd0);
         n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL stall_hold%0d: got %h want %h", k, obs(), e); end
      end
      apply(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
      e = pk(1'b0, RST_PC, 1'b1, 1'b0, {32'h3004, i0});
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL stall_release: got %h want %h", obs(), e); end
      apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      e = pk(1'b1, 32'h3004, 1'b0, 1'b0, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL stall_next_req: got %h want %h", obs(), e); end
      n_cmp++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL stall_count: got %0d want 1", fetch_count); end
   endtask

   task automatic test_redirect_priority();
      logic [98:0] e;
      do_reset();
      apply(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
      apply(1'b1, 1'b1, 32'h0000_4002, 1'b1, $urandom);
      e = pk(1'b1, 32'h3004, 1'b0, 1'b1, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL redir_prio_flush: got %h want %h", obs(), e); end
      apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      e = pk(1'b1, 32'h4000, 1'b0, 1'b0, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL redir_prio_addr: got %h want %h", obs(), e); end
      n_cmp++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL redir_prio_count: got %0d want 1", fetch_count); end
   endtask

   task automatic test_drain();
      logic [98:0] e;
      logic [31:0] c0;
      c0 = $urandom;
      do_reset();
      apply(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
      apply(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
      apply(1'b0, 1'b1, 32'h5000, 1'b0, 32'd0);
      e = pk(1'b1, 32'h3008, 1'b0, 1'b1, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL drain_redirect: got %h want %h", obs(), e); end
      apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      e = pk(1'b1, 32'h3008, 1'b0, 1'b0, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL drain_wait: got %h want %h", obs(), e); end
      apply(1'b0, 1'b0, 32'd0, 1'b1, 32'hBAD0_BAD0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL drain_drop: got %h want %h", obs(), e); end
      apply(1'b0, 1'b0, 32'd0, 1'b1, c0);
      e = pk(1'b1, 32'h5000, 1'b1, 1'b0, {32'h5004, c0});
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL drain_first_pkt: got %h want %h", obs(), e); end
   endtask

   task automatic test_wrap();
      logic [98:0] e;
      logic [31:0] w;
      w = $urandom;
      do_reset();
      apply(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, $urandom);
      apply(1'b0, 1'b0, 32'd0, 1'b1, w);
      e = pk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, {32'h0000_0000, w});
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL wrap_pkt: got %h want %h", obs(), e); end
      apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      n_cmp++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
   endtask

   task automatic test_reset_in_hold();
      logic [98:0] e;
      logic [31:0] q0;
      q0 = $urandom;
      do_reset();
      apply(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
      apply(1'b1, 1'b0, 32'd0, 1'b1, $urandom);
      apply(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      e = pk(1'b0, 32'h3004, 1'b0, 1'b0, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL rsthold_in_hold: got %h want %h", obs(), e); end
      #1 rst = 1'b1; stall = 1'b0;
      #1;
      e = pk(1'b1, RST_PC, 1'b0, 1'b1, 64'd0);
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL rsthold_async: got %h want %h", obs(), e); end
      n_cmp++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL rsthold_count: got %0d want 0", fetch_count); end
      @(negedge clk);
      rst = 1'b0;
      apply(1'b0, 1'b0, 32'd0, 1'b1, q0);
      e = pk(1'b1, RST_PC, 1'b1, 1'b0, {RST_PC + 32'd4, q0});
      n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL rsthold_first_pkt: got %h want %h", obs(), e); end
   endtask

   // Random run against a behavioural model: the model tracks the next pc,
   // the address memory is working on, an optional parked packet and whether
   // the in-flight response is stale.
   task automatic test_random();
      logic [31:0] m_pc, m_req, m_cnt;
      logic        m_parked, m_stale;
      logic [63:0] m_park;
      logic        s, r, a;
      logic [31:0] rpc, rd;
      logic        x_wr, x_fl;
      logic [63:0] x_data;
      logic [98:0] e;
      do_reset();
      m_pc = RST_PC; m_req = RST_PC; m_cnt = 0; m_parked = 0; m_stale = 0; m_park = 0;
      for (int n = 0; n < 800; n++) begin
         s   = ($urandom_range(0, 99) < 35);
         r   = ($urandom_range(0, 99) < 12);
         a   = ($urandom_range(0, 99) < 60);
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC | 32'($urandom_range(0, 3)) : $urandom;
         rd  = $urandom;
         apply(s, r, rpc, a, rd);

         x_wr = 1'b0; x_fl = 1'b0; x_data = 64'd0;
         if (r) begin
            x_fl = 1'b1;
         end else if (m_parked) begin
            if (!s) begin x_wr = 1'b1; x_data = m_park; end
         end else if (!m_stale && a && !s) begin
            x_wr = 1'b1; x_data = {m_pc + 32'd4, rd};
         end
         e = pk(!m_parked, m_req, x_wr, x_fl, x_data);
         n_cmp++; if (obs() !== e) begin n_fail++; $display("FAIL rand_cycle%0d: got %h want %h", n, obs(), e); end
         n_cmp++; if (fetch_count !== m_cnt) begin n_fail++; $display("FAIL rand_count%0d: got %0d want %0d", n, fetch_count, m_cnt); end

         // Advance the model across the coming clock edge.
         if (x_wr) begin
            m_pc = m_pc + 32'd4; m_req = m_pc; m_cnt = m_cnt + 1; m_parked = 1'b0;
         end else if (r) begin
            m_pc = {rpc[31:2], 2'b00};
            if (m_parked) begin
               m_parked = 1'b0; m_req = m_pc;
            end else if (a) begin
               m_stale = 1'b0; m_req = m_pc;
            end else begin
               m_stale = 1'b1;
            end
         end else if (!m_parked && a) begin
            if (m_stale) begin
               m_stale = 1'b0; m_req = m_pc;
            end else begin
               m_parked = 1'b1; m_park = {m_pc + 32'd4, rd};
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      #12 rst = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_priority();
      test_drain();
      test_wrap();
      test_reset_in_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
